keccak_block_packer: RTL and testbench

- Writer-side front end for the keccak controller.
- Accepts message data as a stream of 32-bit words and packs 16 of them into one 512-bit block. It applies Keccak pad10*1 padding on the final word.
- Presents each block to the controller's 512-bit input under a valid/ready handshake, using the controller's in_ready as backpressure.

---
 rtl/keccak_block_packer_pkg.sv | 31 +++
 rtl/keccak_block_packer_if.sv | 43 ++++
 rtl/keccak_block_packer_pad.sv | 23 ++
 rtl/keccak_block_packer.sv | 164 ++++++++++++++++
 tb/tb_keccak_block_packer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/keccak_block_packer_pkg.sv
// Shared types and constants for the keccak block packer.
// Block geometry, pad bytes, FSM states and the byte-mask expander.
package keccak_block_packer_pkg;

  localparam int BLOCK_W = 512;
  localparam int WORDS   = 16;
  localparam int WORD_W  = BLOCK_W / WORDS;
  localparam int BYTES   = BLOCK_W / 8;

  localparam logic [7:0] PAD_FIRST = 8'h01;
  localparam logic [7:0] PAD_LAST  = 8'h80;

  typedef enum logic [1:0] {
    FILL,
    HOLD,
    PADBLK
  } state_t;

  // Byte j of the block lives at bits [BLOCK_W-1-8j -: 8].
  function automatic logic [BLOCK_W-1:0] expand_keep(
    input logic [BYTES-1:0] keep
  );
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int j = 0; j < BYTES; j++) begin
      r[BLOCK_W-1-8*j -: 8] = {8{keep[j]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/keccak_block_packer_if.sv
// Word-in / block-out bus of the keccak block packer.
// master drives words and core_ready; slave is the packer.
interface keccak_block_packer_if;
  import keccak_block_packer_pkg::*;

  logic [WORD_W-1:0]  in32;
  logic               in_valid;
  logic               in_last;
  logic [1:0]         in_bytes;
  logic               word_ready;
  logic [BLOCK_W-1:0] out512;
  logic               out_valid;
  logic               out_last;
  logic               core_ready;
  logic [7:0]         block_cnt;

  modport master (
    output in32,
    output in_valid,
    output in_last,
    output in_bytes,
    output core_ready,
    input  word_ready,
    input  out512,
    input  out_valid,
    input  out_last,
    input  block_cnt
  );

  modport slave (
    input  in32,
    input  in_valid,
    input  in_last,
    input  in_bytes,
    input  core_ready,
    output word_ready,
    output out512,
    output out_valid,
    output out_last,
    output block_cnt
  );

endinterface

// File: rtl/keccak_block_packer_pad.sv
// pad10*1 helper: keep-mask for bytes below p and the pad pattern.
// p=63 folds both pad bytes into a single 0x81.
module keccak_pad_mask
  import keccak_block_packer_pkg::*;
(
  input  logic [5:0]         p,
  output logic [BYTES-1:0]   keep,
  output logic [BLOCK_W-1:0] pad
);

  always_comb begin
    keep = '0;
    pad  = '0;
    for (int j = 0; j < BYTES; j++) begin
      keep[j] = 6'(j) < p;
      if (6'(j) == p) begin
        pad[BLOCK_W-1-8*j -: 8] = PAD_FIRST;
      end
    end
    pad[7:0] = pad[7:0] | PAD_LAST;
  end

endmodule

// File: rtl/keccak_block_packer.sv
// Packs 32-bit message words into 512-bit padded keccak blocks.
// Blocks are held under out_valid until core_ready accepts them.
module keccak_block_packer
  import keccak_block_packer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WORDS  = 16
) (
  input logic clk,
  input logic reset,
  keccak_block_packer_if.slave bus
);

  localparam int KW = $clog2(WORDS);

  state_t state, state_n;

  logic [KW-1:0]      k, k_n;
  logic [BLOCK_W-1:0] blk, blk_n, blk_w;
  logic               vld, vld_n;
  logic               lst, lst_n;
  logic               rdy, rdy_n;
  logic               pend, pend_n;
  logic [7:0]         cnt, cnt_n;

  logic               accept;
  logic               hs;
  logic               at_end;
  logic [2:0]         nb;
  logic [6:0]         p;
  logic [5:0]         pm;
  logic               last_full;
  logic               last_pad;
  logic               full_blk;
  logic [BYTES-1:0]   keep;
  logic [BLOCK_W-1:0] pad;

  assign accept = bus.in_valid & rdy;
  assign hs     = vld & bus.core_ready;
  assign at_end = k == KW'(WORDS - 1);
  assign nb     = (bus.in_bytes == 2'd0) ? 3'd4
                                         : {1'b0, bus.in_bytes};
  assign p      = {1'b0, k, 2'b00} + {4'b0, nb};

  assign last_full = bus.in_last & (p == 7'(BYTES));
  assign last_pad  = bus.in_last & (p != 7'(BYTES));
  assign full_blk  = ~bus.in_last & at_end;

  // PADBLK reuses the same pad unit with p forced to 0.
  assign pm = (state == PADBLK) ? 6'd0 : p[5:0];

  keccak_pad_mask u_pad (
    .p    (pm),
    .keep (keep),
    .pad  (pad)
  );

  always_comb begin
    blk_w = blk;
    blk_w[BLOCK_W-1-DATA_W*int'(k) -: DATA_W] = bus.in32;
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    blk_n   = blk;
    vld_n   = vld;
    lst_n   = lst;
    rdy_n   = rdy;
    pend_n  = pend;
    cnt_n   = cnt;
    unique case (state)
      FILL: begin
        rdy_n = 1'b1;
        if (accept) begin
          blk_n = blk_w;
          k_n   = k + KW'(1);
          unique case (1'b1)
            last_full: begin
              state_n = HOLD;
              vld_n   = 1'b1;
              rdy_n   = 1'b0;
              lst_n   = 1'b0;
              pend_n  = 1'b1;
              k_n     = '0;
            end
            last_pad: begin
              blk_n   = (blk_w & expand_keep(keep)) | pad;
              state_n = HOLD;
              vld_n   = 1'b1;
              rdy_n   = 1'b0;
              lst_n   = 1'b1;
              k_n     = '0;
            end
            full_blk: begin
              state_n = HOLD;
              vld_n   = 1'b1;
              rdy_n   = 1'b0;
              lst_n   = 1'b0;
              k_n     = '0;
            end
            default: ;
          endcase
        end
      end
      HOLD: begin
        rdy_n = 1'b0;
        if (hs) begin
          cnt_n = cnt + 8'd1;
          vld_n = 1'b0;
          k_n   = '0;
          if (pend) begin
            state_n = PADBLK;
          end else begin
            state_n = FILL;
            rdy_n   = 1'b1;
          end
        end
      end
      PADBLK: begin
        blk_n   = pad;
        lst_n   = 1'b1;
        vld_n   = 1'b1;
        rdy_n   = 1'b0;
        pend_n  = 1'b0;
        state_n = HOLD;
      end
      default: begin
        state_n = FILL;
        vld_n   = 1'b0;
        rdy_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
      k     <= '0;
      blk   <= '0;
      vld   <= 1'b0;
      lst   <= 1'b0;
      rdy   <= 1'b0;
      pend  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
      blk   <= blk_n;
      vld   <= vld_n;
      lst   <= lst_n;
      rdy   <= rdy_n;
      pend  <= pend_n;
      cnt   <= cnt_n;
    end
  end

  assign bus.word_ready = rdy;
  assign bus.out512     = blk;
  assign bus.out_valid  = vld;
  assign bus.out_last   = lst;
  assign bus.block_cnt  = cnt;

endmodule

// File: tb/tb_keccak_block_packer.sv
// Scoreboard bench for keccak_block_packer.
// Driver pushes expected blocks; a negedge monitor pops on handshake.
module tb_keccak_block_packer;
  import keccak_block_packer_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  keccak_block_packer_if bus();

  keccak_block_packer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [511:0] blk;
    logic         last;
    logic [7:0]   cnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int n_cmp  = 0;
  int n_bad  = 0;
  int pushed = 0;

  logic [511:0] t1;
  logic [511:0] padblk;

  logic [31:0] wt [8] = '{
    32'h00001111, 32'h22223333, 32'h44445555, 32'h66667777,
    32'h88889999, 32'hAAAABBBB, 32'hCCCCDDDD, 32'hEEEEFFFF
  };

  task automatic chk(input string nm,
                     input logic [511:0] act,
                     input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [511:0] b, input logic l);
    exp_t e;
    e.blk  = b;
    e.last = l;
    e.cnt  = 8'(pushed);
    q.push_back(e);
    pushed++;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] w,
                      input logic last,
                      input logic [1:0] nbytes);
    int t = 0;
    bus.in32     = w;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    bus.in_bytes = nbytes;
    @(negedge clk);
    while (!bus.word_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.word_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got word_ready=0 want 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || bus.out_valid) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    n_cmp++;
    if (q.size() != 0 || bus.out_valid) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.core_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_block: got %h want none", bus.out512);
      end else begin
        mon_e = q.pop_front();
        chk("block_data", bus.out512, mon_e.blk);
        chk("block_last", 512'(bus.out_last), 512'(mon_e.last));
        chk("cnt_at_hs", 512'(bus.block_cnt), 512'(mon_e.cnt));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    bus.in32       = '0;
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
    bus.in_bytes   = 2'd0;
    bus.core_ready = 1'b1;
    t1 = 512'h00001111_22223333_44445555_66667777_88889999_AAAABBBB_CCCCDDDD_EEEEFFFF_00001111_22223333_44445555_66667777_88889999_AAAABBBB_CCCCDDDD_EEEEFFFF;
    padblk = {8'h01, 496'h0, 8'h80};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out512", bus.out512, 512'h0);
    chk("rst_valid", 512'(bus.out_valid), 512'h0);
    chk("rst_last", 512'(bus.out_last), 512'h0);
    chk("rst_ready", 512'(bus.word_ready), 512'h0);
    chk("rst_cnt", 512'(bus.block_cnt), 512'h0);
    reset = 1'b0;

    // Full 16-word block, no padding.
    push(t1, 1'b0);
    for (int i = 0; i < 16; i++) send(wt[i % 8], 1'b0, 2'd0);
    chk("t1_latency_valid", 512'(bus.out_valid), 512'h1);
    chk("t1_ready_low", 512'(bus.word_ready), 512'h0);
    @(posedge clk);
    #1;
    chk("t1_cnt", 512'(bus.block_cnt), 512'h1);
    chk("t1_valid_drop", 512'(bus.out_valid), 512'h0);

    // Single 2-byte word: pad at byte 2.
    push({32'hAABB0100, 448'h0, 32'h00000080}, 1'b1);
    send(32'hAABBCCDD, 1'b1, 2'd2);
    drain();

    // p = 63: both pad bits share the last byte.
    push({t1[511:32], 32'h12345681}, 1'b1);
    for (int i = 0; i < 15; i++) send(wt[i % 8], 1'b0, 2'd0);
    send(32'h12345678, 1'b1, 2'd3);
    drain();

    // p = 64: data block followed by a pure pad block.
    push(t1, 1'b0);
    push(padblk, 1'b1);
    for (int i = 0; i < 16; i++) send(wt[i % 8], i == 15, 2'd0);
    drain();
    chk("p64_cnt", 512'(bus.block_cnt), 512'd5);

    // Backpressure with a word offered during hold.
    bus.core_ready = 1'b0;
    push(t1, 1'b0);
    for (int i = 0; i < 16; i++) send(wt[i % 8], 1'b0, 2'd0);
    push({32'hDEADBEEF, 8'h01, 464'h0, 8'h80}, 1'b1);
    bus.in32     = 32'hDEADBEEF;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    bus.in_bytes = 2'd0;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", 512'(bus.out_valid), 512'h1);
      chk("bp_data", bus.out512, t1);
      chk("bp_ready", 512'(bus.word_ready), 512'h0);
    end
    @(posedge clk);
    #1;
    bus.core_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_ready_back", 512'(bus.word_ready), 512'h1);
    chk("bp_valid_drop", 512'(bus.out_valid), 512'h0);
    chk("bp_cnt", 512'(bus.block_cnt), 512'd6);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    drain();
    chk("bp_cnt2", 512'(bus.block_cnt), 512'd7);

    // Reset mid-block discards the partial words.
    for (int i = 0; i < 5; i++) send(32'hFFFF0000 | 32'(i), 1'b0, 2'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_out512", bus.out512, 512'h0);
    chk("mid_rst_valid", 512'(bus.out_valid), 512'h0);
    chk("mid_rst_last", 512'(bus.out_last), 512'h0);
    chk("mid_rst_ready", 512'(bus.word_ready), 512'h0);
    chk("mid_rst_cnt", 512'(bus.block_cnt), 512'h0);
    reset = 1'b0;
    q.delete();
    pushed = 0;
    push(t1, 1'b0);
    for (int i = 0; i < 16; i++) send(wt[i % 8], 1'b0, 2'd0);
    drain();
    chk("post_rst_cnt", 512'(bus.block_cnt), 512'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
